// File: rtl/mii_rx_framer_if.sv
// MII receive pins plus the frame-buffer write port and end-of-frame status
// of the receive framer, bundled so the framer and its consumer share one port.
interface mii_rx_framer_if;
   logic        recieve_CLK;
   logic [3:0]  recieve;
   logic        recieve_data_valid;
   logic        recieve_ERR;
   logic [15:0] toMemoryE;
   logic [14:0] writeLocationE;
   logic        writeE;
   logic        frameDone;
   logic [10:0] frameLength;
   logic        frameError;

   // framer side: samples the MII pins, drives the write port and status
   modport master (
      input  recieve_CLK, recieve, recieve_data_valid, recieve_ERR,
      output toMemoryE, writeLocationE, writeE, frameDone, frameLength, frameError
   );

   // PHY / memory side
   modport slave (
      output recieve_CLK, recieve, recieve_data_valid, recieve_ERR,
      input  toMemoryE, writeLocationE, writeE, frameDone, frameLength, frameError
   );
endinterface

// File: rtl/mii_rx_framer.sv
// MII receive framer: oversamples the MII RX pins on CLK, strips preamble/SFD,
// packs nibbles into 16-bit words written to sequential frame-buffer addresses
// and reports length/error at each frame end.
// Optional build macro RX_CRC_CHECK_EN adds an FCS (CRC-32) check to frameError.
module mii_rx_framer #(
   parameter logic [14:0] BASE_ADDR = 15'h0000,
   parameter int          MAX_WORDS = 760
) (
   input logic             CLK,
   input logic             resetN,
   mii_rx_framer_if.master rx
);
   localparam logic [14:0] WORD_LIMIT = 15'(MAX_WORDS);
   localparam logic [10:0] COUNT_MAX  = 11'h7FF;

   typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, DONE} state_t;

   state_t      state;
   logic [6:0]  sync1, sync2;     // {rxclk, err, dv, nibble}
   logic        clkPrev;
   logic        stb;
   logic [3:0]  nib;
   logic        dv, err;
   logic        armed;            // dv has been seen low since the last frame
   logic        haveLow;          // low nibble of the current byte is held
   logic        haveHigh;         // first byte of the current word is held
   logic [3:0]  lowNib;
   logic [7:0]  hiByte;
   logic [7:0]  curByte;
   logic [14:0] wordIndex;
   logic [10:0] byteCount;
   logic        errBit;

`ifdef RX_CRC_CHECK_EN
   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   logic [31:0] crc;

   // register kept MSB-first, data bits fed LSB-first as they leave the wire
   function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
         else              r = {r[30:0], 1'b0};
      end
      return r;
   endfunction
`endif

   assign {dv, err} = {sync2[4], sync2[5]};
   assign nib       = sync2[3:0];
   assign stb       = sync2[6] & ~clkPrev;
   assign curByte   = {nib, lowNib};

   // two-flop synchroniser on all MII pins together, plus edge history for stb
   always_ff @(posedge CLK) begin
      if (!resetN) begin
         sync1   <= '0;
         sync2   <= '0;
         clkPrev <= 1'b0;
      end else begin
         sync1   <= {rx.recieve_CLK, rx.recieve_ERR, rx.recieve_data_valid, rx.recieve};
         sync2   <= sync1;
         clkPrev <= sync2[6];
      end
   end

   // framing FSM: advances on stb except DONE, which reports in the next cycle
   always_ff @(posedge CLK) begin
      if (!resetN) begin
         state             <= IDLE;
         armed             <= 1'b0;
         haveLow           <= 1'b0;
         haveHigh          <= 1'b0;
         lowNib            <= '0;
         hiByte            <= '0;
         wordIndex         <= '0;
         byteCount         <= '0;
         errBit            <= 1'b0;
         rx.toMemoryE      <= '0;
         rx.writeLocationE <= '0;
         rx.writeE         <= 1'b0;
         rx.frameDone      <= 1'b0;
         rx.frameLength    <= '0;
         rx.frameError     <= 1'b0;
`ifdef RX_CRC_CHECK_EN
         crc               <= 32'hFFFFFFFF;
`endif
      end else begin
         rx.writeE    <= 1'b0;
         rx.frameDone <= 1'b0;
         if (state == DONE) begin
            rx.frameLength <= byteCount;
`ifdef RX_CRC_CHECK_EN
            rx.frameError  <= errBit | (crc != CRC_RESIDUE) | (byteCount < 11'd4);
`else
            rx.frameError  <= errBit;
`endif
            rx.frameDone   <= 1'b1;
            state          <= IDLE;
         end else if (stb) begin
            case (state)
               IDLE: begin
                  if (!dv) armed <= 1'b1;
                  else begin
                     // a frame only starts from a fresh dv assertion
                     if (armed && nib == 4'h5) state <= PREAMBLE;
                     armed <= 1'b0;
                  end
               end
               PREAMBLE: begin
                  if (dv && nib == 4'hD) begin
                     state     <= DATA;
                     haveLow   <= 1'b0;
                     haveHigh  <= 1'b0;
                     wordIndex <= '0;
                     byteCount <= '0;
                     errBit    <= 1'b0;
`ifdef RX_CRC_CHECK_EN
                     crc       <= 32'hFFFFFFFF;
`endif
                  end else if (!(dv && nib == 4'h5)) begin
                     state <= IDLE;
                     armed <= ~dv;
                  end
               end
               DATA, DROP: begin
                  if (!dv) begin
                     // end of frame: odd nibble is an error, a lone byte is flushed
                     if (haveLow) errBit <= 1'b1;
                     if (haveHigh && state == DATA) begin
                        if (wordIndex == WORD_LIMIT) errBit <= 1'b1;
                        else begin
                           rx.toMemoryE      <= {hiByte, 8'h00};
                           rx.writeLocationE <= BASE_ADDR + wordIndex;
                           rx.writeE         <= 1'b1;
                           wordIndex         <= wordIndex + 15'd1;
                        end
                     end
                     state <= DONE;
                     armed <= 1'b1;
                  end else begin
                     if (err) errBit <= 1'b1;
                     if (!haveLow) begin
                        lowNib  <= nib;
                        haveLow <= 1'b1;
                     end else begin
                        haveLow <= 1'b0;
                        if (byteCount != COUNT_MAX) byteCount <= byteCount + 11'd1;
`ifdef RX_CRC_CHECK_EN
                        crc <= crcByte(crc, curByte);
`endif
                        if (!haveHigh) begin
                           hiByte   <= curByte;
                           haveHigh <= 1'b1;
                        end else begin
                           haveHigh <= 1'b0;
                           // in DROP bytes are still counted but never written
                           if (state == DATA) begin
                              if (wordIndex == WORD_LIMIT) begin
                                 errBit <= 1'b1;
                                 state  <= DROP;
                              end else begin
                                 rx.toMemoryE      <= {hiByte, curByte};
                                 rx.writeLocationE <= BASE_ADDR + wordIndex;
                                 rx.writeE         <= 1'b1;
                                 wordIndex         <= wordIndex + 15'd1;
                              end
                           end
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
